// File: rtl/refclk_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : refclk_seq_pkg
//  Description : Shared types for the refclk CEB sequencer. Holds the 3-bit
//                FSM state encoding and the inclusive pass-band compare used
//                at the end of every measurement window.
//  Revision    : 1.0  initial release
// ============================================================================
package refclk_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_RUN     = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;

    // Inclusive band check; callers zero-extend their count to 32 bits.
    function automatic logic in_band(input logic [31:0] count,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
        return (count >= lo) && (count <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/refclk_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : refclk_edge_sync
//  Description : Two-flop synchronizer for the asynchronous ODIV2 input plus
//                one history flop; emits a single-cycle pulse per rising edge.
//  Ports       : clk     - system clock
//                rst     - synchronous active-high reset
//                i_async - asynchronous divided refclk
//                o_pulse - one-cycle rising-edge detect (s2 & ~s3)
//  Revision    : 1.0  initial release
// ============================================================================
module refclk_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_pulse
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_pulse = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/refclk_ceb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : refclk_ceb_sequencer
//  Description : Gates the GT refclk buffer via CEB for a power-up interval,
//                releases it, then counts ODIV2 rising edges over fixed
//                windows. REFCLK_OK is high while the count stays in band;
//                exhausted retries end in a sticky FAULT.
//  Ports       : CLK        - system clock
//                RST        - synchronous active-high reset
//                ENABLE     - level; low forces IDLE
//                ODIV2_IN   - asynchronous divided refclk from the buffer
//                CEB        - buffer clock-enable, 1 = gated
//                REFCLK_OK  - refclk present and in band (STATE == RUN)
//                FAULT      - sticky retry exhaustion
//                EDGE_COUNT - edge count of the last completed window
//                STATE      - current FSM state encoding
//  Config      : REFCLK_SEQ_STATUS_EN - when defined EDGE_COUNT and STATE are
//                live; otherwise both are tied to 0 and the EDGE_COUNT
//                register is not built.
//  Revision    : 1.0  initial release
// ============================================================================
module refclk_ceb_sequencer
    import refclk_seq_pkg::*;
#(
    parameter int CEB_HOLD_CYCLES = 500,
    parameter int SETTLE_CYCLES   = 64,
    parameter int WINDOW_CYCLES   = 1024,
    parameter int MIN_EDGES       = 240,
    parameter int MAX_EDGES       = 272,
    parameter int RETRY_LIMIT     = 3,
    parameter int EDGE_W          = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE,
    input  logic              ODIV2_IN,
    output logic              CEB,
    output logic              REFCLK_OK,
    output logic              FAULT,
    output logic [EDGE_W-1:0] EDGE_COUNT,
    output logic [2:0]        STATE
);

    // One cycle counter is shared by HOLD, SETTLE and the window.
    localparam int c_CNT_MAX = (CEB_HOLD_CYCLES > SETTLE_CYCLES) ?
                               ((CEB_HOLD_CYCLES > WINDOW_CYCLES) ? CEB_HOLD_CYCLES : WINDOW_CYCLES) :
                               ((SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_RETRY_W = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);

    state_e                 r_state;
    logic [c_CNT_W-1:0]     r_cycle;
    logic [EDGE_W-1:0]      r_edges;
    logic [c_RETRY_W-1:0]   r_retry;
    logic                   r_ceb;
    logic                   r_ok;
    logic                   r_fault;

    logic                   w_pulse;
    logic [EDGE_W-1:0]      w_final;
    logic                   w_pass;
    logic                   w_in_window;
    logic                   w_window_last;

    refclk_edge_sync u_edge_sync (
        .clk     (CLK),
        .rst     (RST),
        .i_async (ODIV2_IN),
        .o_pulse (w_pulse)
    );

    // Running count including this cycle's pulse, saturating at all-ones.
    assign w_final       = (w_pulse && (r_edges != '1)) ? (r_edges + EDGE_W'(1)) : r_edges;
    assign w_pass        = in_band(32'(w_final), 32'(MIN_EDGES), 32'(MAX_EDGES));
    assign w_in_window   = (r_state == ST_MEASURE) || (r_state == ST_RUN);
    assign w_window_last = (r_cycle == c_CNT_W'(WINDOW_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST || !ENABLE) begin
            r_state <= ST_IDLE;
            r_cycle <= '0;
            r_edges <= '0;
            r_retry <= '0;
            r_ceb   <= 1'b1;
            r_ok    <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_HOLD;
                    r_cycle <= '0;
                    r_ceb   <= 1'b1;
                end
                ST_HOLD: begin
                    if (r_cycle == c_CNT_W'(CEB_HOLD_CYCLES - 1)) begin
                        r_state <= ST_SETTLE;
                        r_cycle <= '0;
                        r_ceb   <= 1'b0;
                    end else begin
                        r_cycle <= r_cycle + c_CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (r_cycle == c_CNT_W'(SETTLE_CYCLES - 1)) begin
                        r_state <= ST_MEASURE;
                        r_cycle <= '0;
                        r_edges <= '0;   // pulses seen before the window are dropped
                    end else begin
                        r_cycle <= r_cycle + c_CNT_W'(1);
                    end
                end
                ST_MEASURE, ST_RUN: begin
                    if (w_window_last) begin
                        // Next window (if any) starts on the very next cycle.
                        r_cycle <= '0;
                        r_edges <= '0;
                        if (w_pass) begin
                            r_state <= ST_RUN;
                            r_ok    <= 1'b1;
                            r_retry <= '0;
                        end else if (r_retry == c_RETRY_W'(RETRY_LIMIT)) begin
                            r_state <= ST_FAULT;
                            r_ok    <= 1'b0;
                            r_fault <= 1'b1;
                            r_ceb   <= 1'b1;
                        end else begin
                            r_state <= ST_HOLD;
                            r_ok    <= 1'b0;
                            r_retry <= r_retry + c_RETRY_W'(1);
                            r_ceb   <= 1'b1;
                        end
                    end else begin
                        r_cycle <= r_cycle + c_CNT_W'(1);
                        r_edges <= w_final;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign CEB       = r_ceb;
    assign REFCLK_OK = r_ok;
    assign FAULT     = r_fault;

`ifdef REFCLK_SEQ_STATUS_EN
    logic [EDGE_W-1:0] r_edge_count;

    // Holds across ENABLE drops; only RST clears the last reported count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_edge_count <= '0;
        end else if (ENABLE && w_in_window && w_window_last) begin
            r_edge_count <= w_final;
        end
    end

    assign EDGE_COUNT = r_edge_count;
    assign STATE      = r_state;
`else
    assign EDGE_COUNT = '0;
    assign STATE      = 3'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_refclk_ceb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_refclk_ceb_sequencer
//  Description : Self-checking bench for refclk_ceb_sequencer. ODIV2 is
//                produced as per-window bursts of rising edges; each window's
//                expected outcome is queued when its burst is launched and
//                compared on the cycle the DUT registers the result.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_refclk_ceb_sequencer;

    localparam int HOLD  = 8;
    localparam int SETL  = 4;
    localparam int WIN   = 64;
    localparam int MINE  = 14;
    localparam int MAXE  = 18;
    localparam int RETRY = 2;
    localparam int EW    = 16;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          enable = 1'b0;
    logic          odiv2  = 1'b0;
    logic          ceb;
    logic          ok;
    logic          fault;
    logic [EW-1:0] edge_count;
    logic [2:0]    state;

    always #5 clk = ~clk;

    refclk_ceb_sequencer #(
        .CEB_HOLD_CYCLES (HOLD),
        .SETTLE_CYCLES   (SETL),
        .WINDOW_CYCLES   (WIN),
        .MIN_EDGES       (MINE),
        .MAX_EDGES       (MAXE),
        .RETRY_LIMIT     (RETRY),
        .EDGE_W          (EW)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .ENABLE     (enable),
        .ODIV2_IN   (odiv2),
        .CEB        (ceb),
        .REFCLK_OK  (ok),
        .FAULT      (fault),
        .EDGE_COUNT (edge_count),
        .STATE      (state)
    );

    typedef struct {
        int            id;
        int            at_cyc;
        logic          ceb;
        logic          ok;
        logic          fault;
        logic [EW-1:0] edges;
        logic [2:0]    st;
    } exp_t;

    exp_t sb[$];
    exp_t got;

    int tests      = 0;
    int fails      = 0;
    int cyc        = 0;
    int burst_base = -1000;
    int burst_n    = 0;
    int burst_sp   = 1;
    int gen_rel    = 0;
    int win_id     = 0;
    int m_retry    = 0;
    bit m_run      = 1'b0;

    // Status outputs are only live when the status build option is on.
    function automatic logic [2:0] exp_st(input logic [2:0] s);
`ifdef REFCLK_SEQ_STATUS_EN
        return s;
`else
        return 3'd0;
`endif
    endfunction

    function automatic logic [EW-1:0] exp_ev(input int n);
`ifdef REFCLK_SEQ_STATUS_EN
        return EW'(n);
`else
        return '0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ODIV2 generator: burst_n one-cycle-high pulses, burst_sp apart, from burst_base.
    always @(posedge clk) begin
        #2;
        cyc     = cyc + 1;
        gen_rel = cyc - burst_base;
        odiv2   = (gen_rel >= 0) && (gen_rel < burst_n * burst_sp) && ((gen_rel % burst_sp) == 0);
    end

    // Scoreboard: compare each window outcome on its result cycle.
    always @(posedge clk) begin
        #3;
        if (sb.size() > 0 && sb[0].at_cyc == cyc) begin
            got = sb.pop_front();
            check($sformatf("win%0d_ceb", got.id),   32'(ceb),        32'(got.ceb));
            check($sformatf("win%0d_ok", got.id),    32'(ok),         32'(got.ok));
            check($sformatf("win%0d_fault", got.id), 32'(fault),      32'(got.fault));
            check($sformatf("win%0d_edges", got.id), 32'(edge_count), 32'(got.edges));
            check($sformatf("win%0d_state", got.id), 32'(state),      32'(got.st));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called two cycles before a window starts; returns two cycles before it ends.
    task automatic win(input int n, input int sp);
        exp_t e;
        bit   pass;
        bit   was_run;
        was_run  = m_run;
        pass     = (n >= MINE) && (n <= MAXE);
        e.id     = win_id;
        e.at_cyc = cyc + 67;
        e.edges  = exp_ev(n);
        win_id++;
        if (pass) begin
            m_retry = 0;
            m_run   = 1'b1;
            e.st = exp_st(3'd4); e.ok = 1'b1; e.fault = 1'b0; e.ceb = 1'b0;
        end else if (m_retry == RETRY) begin
            m_run = 1'b0;
            e.st = exp_st(3'd5); e.ok = 1'b0; e.fault = 1'b1; e.ceb = 1'b1;
        end else begin
            m_retry++;
            m_run = 1'b0;
            e.st = exp_st(3'd1); e.ok = 1'b0; e.fault = 1'b0; e.ceb = 1'b1;
        end
        sb.push_back(e);
        burst_n    = n;
        burst_sp   = sp;
        burst_base = cyc + 1;
        repeat (WIN) tick();
        check($sformatf("win%0d_inwin_ok", e.id),    32'(ok),    32'(was_run));
        check($sformatf("win%0d_inwin_state", e.id), 32'(state), 32'(exp_st(was_run ? 3'd4 : 3'd3)));
    endtask

    // After a failed window: CEB held for HOLD cycles, then SETTLE, then next window.
    task automatic gap(input string tag);
        repeat (HOLD + 1) tick();
        check({tag, "_hold_ceb"},   32'(ceb),   32'd1);
        check({tag, "_hold_state"}, 32'(state), 32'(exp_st(3'd1)));
        tick();
        check({tag, "_rel_ceb"},    32'(ceb),   32'd0);
        check({tag, "_rel_state"},  32'(state), 32'(exp_st(3'd2)));
        repeat (2) tick();
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_ceb",   32'(ceb),        32'd1);
        check("rst_ok",    32'(ok),         32'd0);
        check("rst_fault", 32'(fault),      32'd0);
        check("rst_edges", 32'(edge_count), 32'd0);
        check("rst_state", 32'(state),      32'd0);

        // Power-up: CEB falls HOLD cycles after HOLD entry
        rst    = 1'b0;
        enable = 1'b1;
        tick();
        check("pu_hold_state", 32'(state), 32'(exp_st(3'd1)));
        check("pu_hold_ceb",   32'(ceb),   32'd1);
        repeat (HOLD - 1) tick();
        check("pu_last_hold_ceb", 32'(ceb), 32'd1);
        tick();
        check("pu_settle_ceb",   32'(ceb),   32'd0);
        check("pu_settle_state", 32'(state), 32'(exp_st(3'd2)));
        repeat (2) tick();

        // Period-4 window, then in-band boundaries back to back in RUN
        win(16, 4);
        win(14, 3);
        win(18, 3);
        win(13, 3);
        gap("lo13");
        win(19, 3);
        gap("hi19");
        win(16, 4);
        // Period 2 while in RUN: 32 edges, out of band
        win(32, 2);
        gap("p2");
        win(18, 3);

        // Stuck-low ODIV2: three failing attempts end in FAULT
        win(0, 1);
        gap("stuck1");
        win(0, 1);
        gap("stuck2");
        win(0, 1);
        repeat (20) tick();
        check("fault_sticky", 32'(fault), 32'd1);
        check("fault_ceb",    32'(ceb),   32'd1);
        check("fault_ok",     32'(ok),    32'd0);
        check("fault_state",  32'(state), 32'(exp_st(3'd5)));

        // Re-enable from FAULT clears it
        enable = 1'b0;
        tick();
        check("dis_fault", 32'(fault), 32'd0);
        check("dis_state", 32'(state), 32'd0);
        check("dis_ceb",   32'(ceb),   32'd1);
        m_retry = 0;
        m_run   = 1'b0;
        enable  = 1'b1;
        tick();
        check("reen_state", 32'(state), 32'(exp_st(3'd1)));
        repeat (HOLD + 2) tick();
        win(16, 4);

        // ENABLE dropped mid-window in RUN
        repeat (20) tick();
        check("run_mid_ok", 32'(ok), 32'd1);
        enable = 1'b0;
        tick();
        check("drop_state", 32'(state), 32'd0);
        check("drop_ceb",   32'(ceb),   32'd1);
        check("drop_ok",    32'(ok),    32'd0);
        m_run = 1'b0;

        // RST while in SETTLE (ENABLE still high)
        enable = 1'b1;
        tick();
        repeat (HOLD + 1) tick();
        check("pre_rst_state", 32'(state), 32'(exp_st(3'd2)));
        check("pre_rst_ceb",   32'(ceb),   32'd0);
        rst = 1'b1;
        tick();
        check("srst_ceb",   32'(ceb),        32'd1);
        check("srst_ok",    32'(ok),         32'd0);
        check("srst_fault", 32'(fault),      32'd0);
        check("srst_edges", 32'(edge_count), 32'd0);
        check("srst_state", 32'(state),      32'd0);
        rst    = 1'b0;
        enable = 1'b0;
        repeat (4) tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
